key_mode_ctrl: RTL and testbench
================================

KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

Interface
REQ-001 The module SHALL have parameters DB_LEN (default 7; debounce length in cycles) and ADDR_W (default 18; sample address width).
REQ-002 CLK50  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST  in  1  reset; synchronous, active-high.
REQ-004 KEY  in  4  raw push-buttons, active-low: KEY[0] record, KEY[1] play, KEY[2] pause/resume, KEY[3] stop.
REQ-005 sample_tick  in  1  one-cycle strobe from the audio datapath marking one sample slot.
REQ-006 mode  out  3  state: 0 IDLE, 1 RECORD, 2 PLAY, 3 REC_PAUSE, 4 PLAY_PAUSE.
REQ-007 addr  out  ADDR_W  current sample address.
REQ-008 wr_en  out  1  write the sample at addr this cycle; rd_en  out  1  read the sample at addr this cycle.
REQ-009 has_rec  out  1  a non-empty recording exists.

Function
REQ-010 Each key SHALL have a saturating counter: cleared while its KEY is 1, incremented while KEY is 0, saturating at DB_LEN.
REQ-011 A key event SHALL be asserted in the cycle its counter equals DB_LEN-1 and KEY is 0; the FSM acts on the same edge, so mode changes on the DB_LEN-th consecutive low-sampled edge.
REQ-012 A held key SHALL produce exactly one event; a release of any length re-arms it.
REQ-013 With simultaneous events, exactly one SHALL be used, by priority stop > pause > record > play; the rest SHALL be dropped.
REQ-014 IDLE: record -> RECORD, addr=0; play -> PLAY, addr=0, only when has_rec=1; pause/stop ignored.
REQ-015 RECORD: pause -> REC_PAUSE; stop -> IDLE.
REQ-016 PLAY: pause -> PLAY_PAUSE; stop -> IDLE, addr=0.
REQ-017 REC_PAUSE/PLAY_PAUSE: pause -> RECORD/PLAY with addr held; stop -> IDLE; record/play ignored.
REQ-018 Other key/state combinations SHALL be ignored.
REQ-019 wr_en SHALL be combinational: mode==RECORD and sample_tick and no key event this cycle.
REQ-020 rd_en SHALL be combinational: mode==PLAY and sample_tick and no key event this cycle.
REQ-021 On each edge with wr_en or rd_en high, addr SHALL increment by 1 unless an end condition applies.
REQ-022 A key event coincident with sample_tick SHALL win; that tick SHALL be discarded and addr SHALL not advance.
REQ-023 An internal end_addr SHALL hold the last written address.
REQ-024 Stop in RECORD: if addr!=0, end_addr=addr-1 and has_rec=1; else has_rec=0.
REQ-025 A write at addr == 2^ADDR_W-1 SHALL force IDLE, end_addr=2^ADDR_W-1, has_rec=1; addr SHALL not wrap.
REQ-026 Entering RECORD from IDLE SHALL clear has_rec until the next stop or full condition.
REQ-027 A read at addr==end_addr SHALL end playback (see REQ-033).
REQ-028 Pausing SHALL not change addr, end_addr or has_rec.

Reset
REQ-029 While RST=1 at an edge, the next state SHALL be: all key counters 0, mode=0, addr=0, end_addr=0, has_rec=0.
REQ-030 During reset, wr_en and rd_en SHALL be 0.
REQ-031 Reset mid-press SHALL discard the partial count; a still-held key SHALL need DB_LEN fresh low samples after RST falls.
REQ-032 Reset mid-record SHALL discard the recording (has_rec=0).

Configuration
REQ-033 Macro KEY_MODE_CTRL_LOOP_EN: defined -> a read at end_addr sets addr=0 and stays in PLAY (loop playback); undefined -> it sets addr=0 and mode=IDLE.

Verification
REQ-034 DB_LEN=7, KEY[0] low 6 cycles then high -> no event, mode stays 0; low 7 cycles -> mode=1 on 7th edge, addr=0.
REQ-035 RECORD, 5 ticks, then stop -> wr_en pulses 5 times at addr 0..4; end_addr=4, has_rec=1, mode=0.
REQ-036 Play after REQ-035 -> rd_en at addr 0..4, then mode=0, addr=0; with KEY_MODE_CTRL_LOOP_EN, addr returns to 0 and mode stays 2.
REQ-037 KEY[3] and KEY[0] events in the same cycle from IDLE -> stop wins, mode stays 0; in RECORD, pause with sample_tick -> wr_en=0, addr held, mode=3.
REQ-038 ADDR_W=4, recording runs 16 ticks -> last write at addr 15, then mode=0, end_addr=15, has_rec=1.
REQ-039 RST for 1 cycle mid-PLAY at addr 3 -> mode=0, addr=0, has_rec=0; a held KEY[1] causes no event (has_rec=0).

Source files
------------

// File: rtl/key_mode_ctrl.sv
// Push-button record/play controller: debounced keys drive a five-state mode FSM and sample addressing.
// Optional KEY_MODE_CTRL_LOOP_EN: reaching the end of a recording restarts playback instead of idling.
module key_mode_ctrl #(
  parameter int unsigned DB_LEN = 7,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              CLK50,
  input  logic              RST,
  input  logic [3:0]        KEY,
  input  logic              sample_tick,
  output logic [2:0]        mode,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic              rd_en,
  output logic              has_rec
);

  localparam int unsigned CW = $clog2(DB_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_LEN);
  localparam logic [CW-1:0] CNT_EV  = CW'(DB_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] RECORD     = 3'd1;
  localparam logic [2:0] PLAY       = 3'd2;
  localparam logic [2:0] REC_PAUSE  = 3'd3;
  localparam logic [2:0] PLAY_PAUSE = 3'd4;

  logic [CW-1:0]     cnt_q [4];
  logic [3:0]        ev;
  logic              any_ev;
  logic              use_stop, use_pause, use_rec, use_play;
  logic [2:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic              has_rec_q, has_rec_d;

  // One event per press: fires only on the edge the counter reaches saturation.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ev[i] = !KEY[i] && (cnt_q[i] == CNT_EV);
    end
  end

  assign any_ev    = |ev;
  assign use_stop  = ev[3];
  assign use_pause = ev[2] && !ev[3];
  assign use_rec   = ev[0] && !ev[3] && !ev[2];
  assign use_play  = ev[1] && !ev[3] && !ev[2] && !ev[0];

  assign wr_en   = !RST && (mode_q == RECORD) && sample_tick && !any_ev;
  assign rd_en   = !RST && (mode_q == PLAY) && sample_tick && !any_ev;
  assign mode    = mode_q;
  assign addr    = addr_q;
  assign has_rec = has_rec_q;

  always_comb begin
    mode_d     = mode_q;
    addr_d     = addr_q;
    end_addr_d = end_addr_q;
    has_rec_d  = has_rec_q;
    case (mode_q)
      IDLE: begin
        if (use_rec) begin
          mode_d    = RECORD;
          addr_d    = '0;
          has_rec_d = 1'b0;
        end else if (use_play && has_rec_q) begin
          mode_d = PLAY;
          addr_d = '0;
        end
      end
      RECORD: begin
        if (use_stop) begin
          mode_d = IDLE;
          if (addr_q != '0) begin
            end_addr_d = addr_q - 1'b1;
            has_rec_d  = 1'b1;
          end else begin
            has_rec_d = 1'b0;
          end
        end else if (use_pause) begin
          mode_d = REC_PAUSE;
        end else if (wr_en) begin
          // Memory full: keep the final sample and stop without wrapping.
          if (addr_q == ADDR_MAX) begin
            mode_d     = IDLE;
            end_addr_d = ADDR_MAX;
            has_rec_d  = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      PLAY: begin
        if (use_stop) begin
          mode_d = IDLE;
          addr_d = '0;
        end else if (use_pause) begin
          mode_d = PLAY_PAUSE;
        end else if (rd_en) begin
          if (addr_q == end_addr_q) begin
            addr_d = '0;
`ifdef KEY_MODE_CTRL_LOOP_EN
            mode_d = PLAY;
`else
            mode_d = IDLE;
`endif
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      REC_PAUSE: begin
        if (use_stop) begin
          mode_d = IDLE;
        end else if (use_pause) begin
          mode_d = RECORD;
        end
      end
      PLAY_PAUSE: begin
        if (use_stop) begin
          mode_d = IDLE;
        end else if (use_pause) begin
          mode_d = PLAY;
        end
      end
      default: mode_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK50) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      mode_q     <= IDLE;
      addr_q     <= '0;
      end_addr_q <= '0;
      has_rec_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (KEY[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] != CNT_MAX) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      end_addr_q <= end_addr_d;
      has_rec_q  <= has_rec_d;
    end
  end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Scoreboard bench for key_mode_ctrl: expected wr_en/rd_en strobes are queued by the stimulus
// and popped by an independent monitor; mode/addr/has_rec are checked directly between steps.
module tb_key_mode_ctrl;

  localparam int unsigned DB = 7;
  localparam int unsigned AW = 4;

  logic          CLK50 = 1'b0;
  logic          RST;
  logic [3:0]    KEY;
  logic          sample_tick;
  logic [2:0]    mode;
  logic [AW-1:0] addr;
  logic          wr_en;
  logic          rd_en;
  logic          has_rec;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW+1:0] exp_q[$];

  always #5 CLK50 = ~CLK50;

  key_mode_ctrl #(
    .DB_LEN (DB),
    .ADDR_W (AW)
  ) dut (
    .CLK50       (CLK50),
    .RST         (RST),
    .KEY         (KEY),
    .sample_tick (sample_tick),
    .mode        (mode),
    .addr        (addr),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .has_rec     (has_rec)
  );

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Strobe monitor: {rd_en, wr_en, addr}
  always @(negedge CLK50) begin
    if (wr_en || rd_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got rd=%0d wr=%0d addr=%0d, expected none",
                 rd_en, wr_en, addr);
      end else begin
        logic [AW+1:0] e;
        e = exp_q.pop_front();
        check("strobe", int'({rd_en, wr_en, addr}), int'(e));
      end
    end
  end

  task automatic step();
    @(posedge CLK50);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic push(input logic rd, input logic wr, input int a);
    logic [AW-1:0] av;
    av = AW'(a);
    exp_q.push_back({rd, wr, av});
  endtask

  task automatic press(input logic [3:0] mask);
    KEY = KEY & ~mask;
    repeat (DB) step();
    KEY = KEY | mask;
    step();
  endtask

  initial begin
    KEY         = 4'hF;
    sample_tick = 1'b0;
    RST         = 1'b1;
    step();
    step();
    sample_tick = 1'b1;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_rd_en", int'(rd_en), 0);
    step();
    sample_tick = 1'b0;
    RST = 1'b0;
    check("rst_mode", int'(mode), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_has_rec", int'(has_rec), 0);

    // Six low samples are one short of an event
    KEY[0] = 1'b0;
    repeat (DB - 1) step();
    KEY[0] = 1'b1;
    step();
    check("short_press_mode", int'(mode), 0);

    KEY[0] = 1'b0;
    repeat (DB - 1) step();
    check("pre_event_mode", int'(mode), 0);
    step();
    check("rec_mode", int'(mode), 1);
    check("rec_addr", int'(addr), 0);
    KEY[0] = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      push(1'b0, 1'b1, i);
      tick();
    end
    press(4'b1000);
    check("stop_mode", int'(mode), 0);
    check("stop_has_rec", int'(has_rec), 1);

    for (int i = 0; i < 5; i++) push(1'b1, 1'b0, i);
    press(4'b0010);
    check("play_mode", int'(mode), 2);
    check("play_addr", int'(addr), 0);
    repeat (5) tick();
`ifdef KEY_MODE_CTRL_LOOP_EN
    check("loop_mode", int'(mode), 2);
    check("loop_addr", int'(addr), 0);
    press(4'b1000);
    check("loop_stop_mode", int'(mode), 0);
`else
    check("play_end_mode", int'(mode), 0);
    check("play_end_addr", int'(addr), 0);
`endif

    // Stop outranks record when both fire together
    press(4'b1001);
    check("simul_mode", int'(mode), 0);
    check("simul_has_rec", int'(has_rec), 1);

    press(4'b0001);
    check("rec2_mode", int'(mode), 1);
    check("rec2_has_rec", int'(has_rec), 0);
    push(1'b0, 1'b1, 0);
    tick();
    push(1'b0, 1'b1, 1);
    tick();
    KEY[2] = 1'b0;
    repeat (DB - 1) step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("pause_mode", int'(mode), 3);
    check("pause_addr", int'(addr), 2);
    KEY[2] = 1'b1;
    step();
    tick();
    check("paused_tick_addr", int'(addr), 2);
    press(4'b0100);
    check("resume_mode", int'(mode), 1);
    check("resume_addr", int'(addr), 2);
    push(1'b0, 1'b1, 2);
    tick();
    press(4'b1000);
    check("rec2_stop_has_rec", int'(has_rec), 1);

    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, i);
    press(4'b0010);
    repeat (3) tick();
`ifdef KEY_MODE_CTRL_LOOP_EN
    check("play2_loop_mode", int'(mode), 2);
    press(4'b1000);
`endif
    check("play2_end_mode", int'(mode), 0);

    // Stopping before any write leaves no recording
    press(4'b0001);
    press(4'b1000);
    check("empty_has_rec", int'(has_rec), 0);
    press(4'b0010);
    check("empty_play_mode", int'(mode), 0);

    press(4'b0001);
    for (int i = 0; i < 16; i++) begin
      push(1'b0, 1'b1, i);
      tick();
    end
    check("full_mode", int'(mode), 0);
    check("full_addr", int'(addr), 15);
    check("full_has_rec", int'(has_rec), 1);

    for (int i = 0; i < 16; i++) push(1'b1, 1'b0, i);
    press(4'b0010);
    repeat (16) tick();
`ifdef KEY_MODE_CTRL_LOOP_EN
    check("full_loop_mode", int'(mode), 2);
    check("full_loop_addr", int'(addr), 0);
    press(4'b1000);
`else
    check("full_play_mode", int'(mode), 0);
    check("full_play_addr", int'(addr), 0);
`endif

    // Reset mid-playback with KEY[1] still held
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, i);
    KEY[1] = 1'b0;
    repeat (DB) step();
    check("rstplay_mode", int'(mode), 2);
    repeat (3) tick();
    check("rstplay_addr", int'(addr), 3);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("post_rst_mode", int'(mode), 0);
    check("post_rst_addr", int'(addr), 0);
    check("post_rst_has_rec", int'(has_rec), 0);
    repeat (2 * DB) step();
    check("held_key_mode", int'(mode), 0);
    KEY[1] = 1'b1;
    step();
    step();
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
